// File: rtl/dmem_pkg.sv
// Shared constants for the MEM-stage data-memory responder: access-type codes and MMIO map.
package dmem_pkg;

  localparam logic [2:0] RW_B  = 3'b000;
  localparam logic [2:0] RW_H  = 3'b001;
  localparam logic [2:0] RW_W  = 3'b010;
  localparam logic [2:0] RW_BU = 3'b100;
  localparam logic [2:0] RW_HU = 3'b101;

  localparam logic [15:0] MMIO_GPIO       = 16'h0000;
  localparam logic [15:0] MMIO_CYCLE      = 16'h0004;
  localparam logic [15:0] MMIO_HI_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/dmem_lane_unit.sv
// Byte-lane steering for one access: store byte enables and replicated data, extended load data, fault flag.
// Purely combinational, zero latency; no flow control.
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [2:0]  i_rw_type,
  input  logic [1:0]  i_addr,
  input  logic        i_is_write,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rd_word,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata,
  output logic        o_fault
);

  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_shifted = i_rd_word >> {i_addr, 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = i_addr[1] ? i_rd_word[31:16] : i_rd_word[15:0];

  always_comb begin
    o_be    = 4'b0000;
    o_wdata = '0;
    o_ldata = '0;
    o_fault = 1'b0;
    case (i_rw_type)
      RW_B: begin
        o_be    = 4'b0001 << i_addr;
        o_wdata = {4{i_store_data[7:0]}};
        o_ldata = {{24{w_byte[7]}}, w_byte};
      end
      RW_H: begin
        o_fault = i_addr[0];
        o_be    = i_addr[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_store_data[15:0]}};
        o_ldata = {{16{w_half[15]}}, w_half};
      end
      RW_W: begin
        o_fault = (i_addr != 2'b00);
        o_be    = 4'b1111;
        o_wdata = i_store_data;
        o_ldata = i_rd_word;
      end
      // Unsigned variants exist only as loads.
      RW_BU: begin
        o_fault = i_is_write;
        o_ldata = {24'd0, w_byte};
      end
      RW_HU: begin
        o_fault = i_is_write | i_addr[0];
        o_ldata = {16'd0, w_half};
      end
      default: o_fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory: word RAM plus GPIO/CYCLE MMIO; loads combinational, stores commit at the edge.
// Always ready (no backpressure); faulted accesses are dropped and reported by a one-cycle err_valid pulse.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [15:0] MMIO_HI    = MMIO_HI_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        R_en,
  input  logic        W_en,
  input  logic [2:0]  RW_type,
  input  logic [31:0] ram_addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] gpio_out,
  output logic        err_valid,
  output logic [31:0] err_addr
);

  logic [31:0] r_mem [2**ADDR_WIDTH];
  logic [31:0] r_gpio;
  logic [31:0] r_cycle;
  logic        r_err_valid;
  logic [31:0] r_err_addr;

  logic [ADDR_WIDTH-1:0] w_widx;
  logic        w_is_mmio;
  logic        w_sel_gpio;
  logic        w_sel_cycle;
  logic [31:0] w_rd_word;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ldata;
  logic        w_lane_fault;
  logic        w_fault;
  logic        w_we;

  assign w_widx      = ram_addr[ADDR_WIDTH+1:2];
  assign w_is_mmio   = (ram_addr[31:16] == MMIO_HI);
  // Registers decode on the word offset so byte/half accesses hit any lane of them.
  assign w_sel_gpio  = w_is_mmio && (ram_addr[15:2] == MMIO_GPIO[15:2]);
  assign w_sel_cycle = w_is_mmio && (ram_addr[15:2] == MMIO_CYCLE[15:2]);

  always_comb begin
    w_rd_word = r_mem[w_widx];
    if (w_is_mmio) begin
      w_rd_word = w_sel_gpio ? r_gpio : (w_sel_cycle ? r_cycle : '0);
    end
  end

  dmem_lane_unit u_lane (
    .i_rw_type    (RW_type),
    .i_addr       (ram_addr[1:0]),
    .i_is_write   (W_en),
    .i_store_data (store_data),
    .i_rd_word    (w_rd_word),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_ldata      (w_ldata),
    .o_fault      (w_lane_fault)
  );

  assign w_fault   = (R_en | W_en) & (w_lane_fault | (R_en & W_en));
  assign w_we      = W_en & ~w_fault & ~rst;
  assign load_data = (R_en & ~w_fault) ? w_ldata : '0;

  always_ff @(posedge clk) begin
    if (w_we && !w_is_mmio) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_widx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gpio <= '0;
    end else if (w_we && w_sel_gpio) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_gpio[8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  // Only a full-word store may load the counter; narrower stores leave it counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle <= '0;
    end else if (w_we && w_sel_cycle && (RW_type == RW_W)) begin
      r_cycle <= store_data;
    end else begin
      r_cycle <= r_cycle + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
    end else begin
      r_err_valid <= w_fault;
      if (w_fault) r_err_addr <= ram_addr;
    end
  end

  assign gpio_out  = r_gpio;
  assign err_valid = r_err_valid;
  assign err_addr  = r_err_addr;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-addressed reference model, plus directed scenarios.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        R_en = 1'b0;
  logic        W_en = 1'b0;
  logic [2:0]  RW_type = 3'b000;
  logic [31:0] ram_addr = '0;
  logic [31:0] store_data = '0;
  logic [31:0] load_data;
  logic [31:0] gpio_out;
  logic        err_valid;
  logic [31:0] err_addr;

  dmem_responder #(.ADDR_WIDTH(8), .MMIO_HI(16'hFFFF)) dut (
    .clk        (clk),
    .rst        (rst),
    .R_en       (R_en),
    .W_en       (W_en),
    .RW_type    (RW_type),
    .ram_addr   (ram_addr),
    .store_data (store_data),
    .load_data  (load_data),
    .gpio_out   (gpio_out),
    .err_valid  (err_valid),
    .err_addr   (err_addr)
  );

  always #5 clk = ~clk;

  // Reference state: RAM as 1 KiB of bytes, MMIO registers, pending error report.
  logic [7:0]  m_ram [1024];
  logic [31:0] m_gpio  = '0;
  logic [31:0] m_cycle = '0;
  logic        m_errv  = 1'b0;
  logic [31:0] m_erra  = '0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] obs_ld, obs_ea, obs_gpio;
  logic        obs_ev;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int acc_size(input logic [2:0] t);
    case (t[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic is_fault(input logic r, input logic w, input logic [2:0] t,
                                    input logic [31:0] a);
    int  sz;
    logic legal;
    sz = acc_size(t);
    if (w) legal = (t == 3'd0 || t == 3'd1 || t == 3'd2);
    else   legal = (t == 3'd0 || t == 3'd1 || t == 3'd2 || t == 3'd4 || t == 3'd5);
    if (!(r || w)) return 1'b0;
    if (r && w) return 1'b1;
    if (!legal) return 1'b1;
    return (a % sz) != 0;
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    int base;
    if (a[31:16] == 16'hFFFF) begin
      if (a[15:0] / 4 == 0) return m_gpio;
      if (a[15:0] / 4 == 1) return m_cycle;
      return 32'd0;
    end
    base = int'(a % 1024) / 4 * 4;
    return {m_ram[base+3], m_ram[base+2], m_ram[base+1], m_ram[base]};
  endfunction

  function automatic logic [31:0] exp_load(input logic r, input logic w, input logic [2:0] t,
                                           input logic [31:0] a);
    logic [31:0] v;
    if (!r || is_fault(r, w, t, a)) return 32'd0;
    v = word_at(a) >> (8 * int'(a % 4));
    case (acc_size(t))
      1:       return t[2] ? {24'd0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
      2:       return t[2] ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      default: return v;
    endcase
  endfunction

  task automatic model_step(input logic rs, input logic r, input logic w, input logic [2:0] t,
                            input logic [31:0] a, input logic [31:0] d);
    logic        f;
    logic [31:0] nxt_cycle;
    int          sz, lane;
    f = is_fault(r, w, t, a);
    if (rs) begin
      m_gpio = '0; m_cycle = '0; m_errv = 1'b0; m_erra = '0;
      return;
    end
    nxt_cycle = m_cycle + 1;
    if (w && !f) begin
      sz = acc_size(t);
      for (int i = 0; i < sz; i++) begin
        lane = int'(a % 4) + i;
        if (a[31:16] != 16'hFFFF) m_ram[int'(a % 1024) / 4 * 4 + lane] = d[8*i +: 8];
        else if (a[15:0] / 4 == 0) m_gpio[8*lane +: 8] = d[8*i +: 8];
      end
      if (a[31:16] == 16'hFFFF && a[15:0] / 4 == 1 && sz == 4) nxt_cycle = d;
    end
    m_cycle = nxt_cycle;
    m_errv  = f;
    if (f) m_erra = a;
  endtask

  // Drives one access for one cycle, checks outputs mid-cycle, then advances the model past the edge.
  task automatic do_cycle(input logic rs, input logic r, input logic w, input logic [2:0] t,
                          input logic [31:0] a, input logic [31:0] d);
    rst = rs; R_en = r; W_en = w; RW_type = t; ram_addr = a; store_data = d;
    #4;
    obs_ld = load_data; obs_ev = err_valid; obs_ea = err_addr; obs_gpio = gpio_out;
    check_eq("load_data", obs_ld, exp_load(r, w, t, a));
    check_eq("err_valid", {31'd0, obs_ev}, {31'd0, m_errv});
    check_eq("err_addr", obs_ea, m_erra);
    check_eq("gpio_out", obs_gpio, m_gpio);
    @(posedge clk);
    #1;
    model_step(rs, r, w, t, a, d);
  endtask

  task automatic idle();
    do_cycle(1'b0, 1'b0, 1'b0, RW_W, 32'd0, 32'd0);
  endtask

  logic [2:0]  legal_types [5] = '{RW_B, RW_H, RW_W, RW_BU, RW_HU};
  logic        rr, ww;
  logic [2:0]  tt;
  logic [31:0] aa;

  initial begin
    for (int i = 0; i < 1024; i++) m_ram[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_gpio", gpio_out, 32'd0);
    check_eq("rst_err_valid", {31'd0, err_valid}, 32'd0);
    check_eq("rst_err_addr", err_addr, 32'd0);

    // Give every RAM word a defined value.
    for (int i = 0; i < 256; i++) do_cycle(1'b0, 1'b0, 1'b1, RW_W, 32'(i * 4), $urandom);

    // Byte lanes and extension.
    do_cycle(1'b0, 1'b0, 1'b1, RW_W, 32'h10, 32'h80FF_7F01);
    do_cycle(1'b0, 1'b1, 1'b0, RW_B, 32'h13, 32'd0);
    check_eq("lb_0x13", obs_ld, 32'hFFFF_FF80);
    do_cycle(1'b0, 1'b1, 1'b0, RW_BU, 32'h13, 32'd0);
    check_eq("lbu_0x13", obs_ld, 32'h0000_0080);
    do_cycle(1'b0, 1'b1, 1'b0, RW_H, 32'h10, 32'd0);
    check_eq("lh_0x10", obs_ld, 32'h0000_7F01);
    do_cycle(1'b0, 1'b1, 1'b0, RW_HU, 32'h12, 32'd0);
    check_eq("lhu_0x12", obs_ld, 32'h0000_80FF);

    // Partial stores.
    do_cycle(1'b0, 1'b0, 1'b1, RW_W, 32'h10, 32'h1122_3344);
    do_cycle(1'b0, 1'b0, 1'b1, RW_H, 32'h12, 32'h0000_BEEF);
    do_cycle(1'b0, 1'b1, 1'b0, RW_W, 32'h10, 32'd0);
    check_eq("sh_merge", obs_ld, 32'hBEEF_3344);
    do_cycle(1'b0, 1'b0, 1'b1, RW_B, 32'h11, 32'h0000_00AA);
    do_cycle(1'b0, 1'b1, 1'b0, RW_W, 32'h10, 32'd0);
    check_eq("sb_merge", obs_ld, 32'hBEEF_AA44);

    // Misaligned accesses.
    do_cycle(1'b0, 1'b0, 1'b1, RW_W, 32'h20, 32'h5566_7788);
    do_cycle(1'b0, 1'b1, 1'b0, RW_W, 32'h22, 32'd0);
    check_eq("mis_lw_data", obs_ld, 32'd0);
    idle();
    check_eq("mis_err_valid", {31'd0, obs_ev}, 32'd1);
    check_eq("mis_err_addr", obs_ea, 32'h22);
    do_cycle(1'b0, 1'b0, 1'b1, RW_H, 32'h21, 32'h0000_FFFF);
    do_cycle(1'b0, 1'b1, 1'b0, RW_W, 32'h20, 32'd0);
    check_eq("mis_sh_kept", obs_ld, 32'h5566_7788);
    check_eq("mis_sh_err", {31'd0, obs_ev}, 32'd1);

    // Illegal accesses.
    do_cycle(1'b0, 1'b1, 1'b1, RW_W, 32'h20, 32'hFFFF_FFFF);
    do_cycle(1'b0, 1'b1, 1'b0, RW_W, 32'h20, 32'd0);
    check_eq("rw_both_kept", obs_ld, 32'h5566_7788);
    check_eq("rw_both_err", {31'd0, obs_ev}, 32'd1);
    do_cycle(1'b0, 1'b1, 1'b0, 3'b111, 32'h30, 32'd0);
    idle();
    check_eq("type7_err", {31'd0, obs_ev}, 32'd1);
    check_eq("type7_addr", obs_ea, 32'h30);

    // MMIO.
    do_cycle(1'b0, 1'b0, 1'b1, RW_B, 32'hFFFF_0001, 32'h0000_005A);
    idle();
    check_eq("gpio_sb", obs_gpio, 32'h0000_5A00);
    do_cycle(1'b0, 1'b0, 1'b1, RW_W, 32'hFFFF_0004, 32'hFFFF_FFFE);
    idle();
    do_cycle(1'b0, 1'b1, 1'b0, RW_W, 32'hFFFF_0004, 32'd0);
    check_eq("cycle_ffff", obs_ld, 32'hFFFF_FFFF);
    do_cycle(1'b0, 1'b1, 1'b0, RW_W, 32'hFFFF_0004, 32'd0);
    check_eq("cycle_wrap", obs_ld, 32'd0);

    // Reset suppresses stores and restarts CYCLE.
    do_cycle(1'b0, 1'b0, 1'b1, RW_W, 32'h40, 32'h1234_5678);
    do_cycle(1'b1, 1'b0, 1'b1, RW_W, 32'h40, 32'hDEAD_BEEF);
    do_cycle(1'b1, 1'b0, 1'b1, RW_W, 32'hFFFF_0000, 32'hDEAD_BEEF);
    do_cycle(1'b0, 1'b1, 1'b0, RW_W, 32'hFFFF_0004, 32'd0);
    check_eq("rst_cycle0", obs_ld, 32'd0);
    do_cycle(1'b0, 1'b1, 1'b0, RW_W, 32'hFFFF_0004, 32'd0);
    check_eq("rst_cycle1", obs_ld, 32'd1);
    do_cycle(1'b0, 1'b1, 1'b0, RW_W, 32'h40, 32'd0);
    check_eq("rst_ram_kept", obs_ld, 32'h1234_5678);
    check_eq("rst_gpio_0", obs_gpio, 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 2500; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin rr = 1'b1; ww = 1'b0; end
        4, 5, 6, 7: begin rr = 1'b0; ww = 1'b1; end
        8:          begin rr = 1'b1; ww = 1'b1; end
        default:    begin rr = 1'b0; ww = 1'b0; end
      endcase
      if ($urandom_range(0, 9) < 8) tt = legal_types[$urandom_range(0, 4)];
      else                         tt = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0, 1:    aa = 32'($urandom_range(0, 255));
        2:       aa = $urandom;
        default: aa = {16'hFFFF, 16'($urandom_range(0, 11))};
      endcase
      do_cycle(1'b0, rr, ww, tt, aa, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
